// File: rtl/cond_exec_unit_if.sv
// Decoder-to-condition-unit bundle.
// Master drives the instruction side, slave returns predication.
interface cond_exec_unit_if #(
  parameter int NBANKS = 2,
  parameter int MAX_IT = 4,
  parameter int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  parameter int LW     = $clog2(MAX_IT + 1)
);
  logic              en;
  logic              flush;
  logic [BW-1:0]     bank_sel;
  logic [3:0]        Cond;
  logic [3:0]        ALUFlags;
  logic [1:0]        FlagW;
  logic              it_start;
  logic [3:0]        it_cond;
  logic [LW-1:0]     it_len;
  logic [MAX_IT-1:0] it_then;
  logic              CondEx;
  logic [3:0]        Flags;
  logic              it_active;
  logic [LW-1:0]     it_remaining;
  logic              it_err;

  modport master (
    output en, flush, bank_sel, Cond,
    output ALUFlags, FlagW,
    output it_start, it_cond, it_len, it_then,
    input  CondEx, Flags, it_active,
    input  it_remaining, it_err
  );

  modport slave (
    input  en, flush, bank_sel, Cond,
    input  ALUFlags, FlagW,
    input  it_start, it_cond, it_len, it_then,
    output CondEx, Flags, it_active,
    output it_remaining, it_err
  );
endinterface

// File: rtl/cond_exec_unit.sv
// Banked NZCV flags, ARM condition check and IT-block sequencer.
// CondEx is combinational on registered state plus current inputs.
module cond_exec_unit #(
  parameter int NBANKS = 2,
  parameter int MAX_IT = 4,
  parameter int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1,
  parameter int LW     = $clog2(MAX_IT + 1)
) (
  input logic clk,
  input logic reset,
  cond_exec_unit_if.slave bus
);

  logic [3:0]        bank_q [NBANKS];
  logic [3:0]        flags;
  logic              act_q;
  logic [LW-1:0]     rem_q;
  logic [3:0]        base_q;
  logic [MAX_IT-1:0] mask_q;
  logic              err_q;
  logic [3:0]        ec;
  logic              cond_ok;
  logic              cex;
  logic              upd;
  logic              len_ok;

  // Select the registered flags of the addressed bank.
  always_comb begin
    flags = 4'b0000;
    for (int i = 0; i < NBANKS; i++) begin
      if (bus.bank_sel == BW'(i)) flags = bank_q[i];
    end
  end

  // Effective condition: decoder field outside IT, slot cond inside.
  always_comb begin
    ec = bus.Cond;
    if (act_q) begin
      if (base_q == 4'b1110) ec = base_q;
      else ec = {base_q[3:1], base_q[0] ^ ~mask_q[0]};
    end
  end

  // Evaluate the condition code against the selected flags.
  always_comb begin
    logic n, z, c, v, ge;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    ge = (n == v);
    cond_ok = 1'b1;
    unique case (ec)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = ~z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = ~c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = ~n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = ~v;
      4'b1000: cond_ok = c & ~z;
      4'b1001: cond_ok = ~(c & ~z);
      4'b1010: cond_ok = ge;
      4'b1011: cond_ok = ~ge;
      4'b1100: cond_ok = ~z & ge;
      4'b1101: cond_ok = ~(~z & ge);
      4'b1110,
      4'b1111: cond_ok = 1'b1;
    endcase
  end

  // The IT instruction itself always executes.
  always_comb begin
    cex = cond_ok;
    if (bus.it_start && !act_q) cex = 1'b1;
  end

  assign upd    = bus.en && !bus.flush && cex;
  assign len_ok = (bus.it_len != '0) &&
                  (bus.it_len <= LW'(MAX_IT));

  // Flag banks: only the selected bank is written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NBANKS; i++) bank_q[i] <= 4'b0000;
    end else if (upd) begin
      for (int i = 0; i < NBANKS; i++) begin
        if (bus.bank_sel == BW'(i)) begin
          if (bus.FlagW[1]) bank_q[i][3:2] <= bus.ALUFlags[3:2];
          if (bus.FlagW[0]) bank_q[i][1:0] <= bus.ALUFlags[1:0];
        end
      end
    end
  end

  // IT sequencer: load, consume slots, flag misuse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      act_q  <= 1'b0;
      rem_q  <= '0;
      base_q <= 4'b0000;
      mask_q <= '0;
      err_q  <= 1'b0;
    end else if (bus.flush) begin
      act_q <= 1'b0;
      rem_q <= '0;
      if (bus.en) err_q <= 1'b0;
    end else if (bus.en) begin
      if (act_q) begin
        rem_q  <= rem_q - LW'(1);
        mask_q <= mask_q >> 1;
        act_q  <= (rem_q != LW'(1));
        err_q  <= bus.it_start;
      end else if (bus.it_start) begin
        if (len_ok) begin
          base_q <= bus.it_cond;
          mask_q <= bus.it_then;
          rem_q  <= bus.it_len;
          act_q  <= 1'b1;
          err_q  <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end else begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.CondEx       = cex;
  assign bus.Flags        = flags;
  assign bus.it_active    = act_q;
  assign bus.it_remaining = rem_q;
  assign bus.it_err       = err_q;

endmodule

// File: tb/tb_cond_exec_unit.sv
// Directed bench for cond_exec_unit.
// Hand-computed expectations per vector.
module tb_cond_exec_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  cond_exec_unit_if #(.NBANKS(2), .MAX_IT(4)) bus ();

  cond_exec_unit #(.NBANKS(2), .MAX_IT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [7:0] got,
                       input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.en = 1'b0;
    bus.flush = 1'b0;
    bus.bank_sel = 1'b0;
    bus.Cond = 4'b1110;
    bus.ALUFlags = 4'b0000;
    bus.FlagW = 2'b00;
    bus.it_start = 1'b0;
    bus.it_cond = 4'b0000;
    bus.it_len = 3'd0;
    bus.it_then = 4'b0000;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Pre-write bank 0 and open an IT block, then async reset.
    bus.en = 1'b1;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b1111;
    bus.it_start = 1'b1;
    bus.it_cond = 4'b1110;
    bus.it_len = 3'd2;
    bus.it_then = 4'b0011;
    tick();
    bus.it_start = 1'b0;
    bus.FlagW = 2'b00;
    bus.en = 1'b0;
    settle();
    check("prewr_flags", 8'(bus.Flags), 8'h0f);
    check("prewr_act", 8'(bus.it_active), 8'h1);
    #1;
    reset = 1'b0;
    #1;
    check("rst_flags", 8'(bus.Flags), 8'h00);
    check("rst_act", 8'(bus.it_active), 8'h0);
    check("rst_rem", 8'(bus.it_remaining), 8'h0);
    check("rst_err", 8'(bus.it_err), 8'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Bank 0 write, then bank switch.
    bus.en = 1'b1;
    bus.bank_sel = 1'b0;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b0100;
    bus.Cond = 4'b1110;
    settle();
    check("al_cex", 8'(bus.CondEx), 8'h1);
    tick();
    bus.FlagW = 2'b00;
    bus.Cond = 4'b0000;
    settle();
    check("b0_flags", 8'(bus.Flags), 8'h04);
    check("b0_eq", 8'(bus.CondEx), 8'h1);
    bus.bank_sel = 1'b1;
    settle();
    check("b1_flags", 8'(bus.Flags), 8'h00);
    check("b1_eq", 8'(bus.CondEx), 8'h0);

    // Signed compares: N=1,V=0 then N=1,V=1.
    bus.bank_sel = 1'b0;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b1000;
    bus.Cond = 4'b1110;
    tick();
    bus.FlagW = 2'b00;
    bus.Cond = 4'b1010;
    settle();
    check("ge_nv10", 8'(bus.CondEx), 8'h0);
    bus.Cond = 4'b1011;
    settle();
    check("lt_nv10", 8'(bus.CondEx), 8'h1);
    bus.Cond = 4'b1101;
    settle();
    check("le_nv10", 8'(bus.CondEx), 8'h1);
    bus.Cond = 4'b1000;
    settle();
    check("hi_c0", 8'(bus.CondEx), 8'h0);
    bus.FlagW = 2'b01;
    bus.ALUFlags = 4'b0001;
    bus.Cond = 4'b1110;
    tick();
    bus.FlagW = 2'b00;
    bus.Cond = 4'b1010;
    settle();
    check("cv_flags", 8'(bus.Flags), 8'h09);
    check("ge_nv11", 8'(bus.CondEx), 8'h1);

    // IT EQ, len 3, then/else/then with Z=1.
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b0100;
    bus.Cond = 4'b1110;
    tick();
    bus.FlagW = 2'b00;
    bus.Cond = 4'b0001;
    bus.it_start = 1'b1;
    bus.it_cond = 4'b0000;
    bus.it_len = 3'd3;
    bus.it_then = 4'b0101;
    settle();
    check("it_forced", 8'(bus.CondEx), 8'h1);
    tick();
    bus.it_start = 1'b0;
    settle();
    check("s1_rem", 8'(bus.it_remaining), 8'h3);
    check("s1_act", 8'(bus.it_active), 8'h1);
    check("s1_cex", 8'(bus.CondEx), 8'h1);
    tick();
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b1111;
    settle();
    check("s2_rem", 8'(bus.it_remaining), 8'h2);
    check("s2_cex", 8'(bus.CondEx), 8'h0);
    tick();
    bus.FlagW = 2'b00;
    settle();
    check("s2_keep", 8'(bus.Flags), 8'h04);
    check("s3_rem", 8'(bus.it_remaining), 8'h1);
    check("s3_act", 8'(bus.it_active), 8'h1);
    check("s3_cex", 8'(bus.CondEx), 8'h1);
    tick();
    check("end_rem", 8'(bus.it_remaining), 8'h0);
    check("end_act", 8'(bus.it_active), 8'h0);

    // AL block len 4: hold with en=0, then flush.
    bus.it_start = 1'b1;
    bus.it_cond = 4'b1110;
    bus.it_len = 3'd4;
    bus.it_then = 4'b0000;
    tick();
    bus.it_start = 1'b0;
    bus.en = 1'b0;
    tick();
    tick();
    check("hold_rem", 8'(bus.it_remaining), 8'h4);
    check("hold_act", 8'(bus.it_active), 8'h1);
    check("al_else", 8'(bus.CondEx), 8'h1);
    bus.en = 1'b1;
    tick();
    check("fl_pre_rem", 8'(bus.it_remaining), 8'h3);
    bus.flush = 1'b1;
    bus.FlagW = 2'b11;
    bus.ALUFlags = 4'b0010;
    tick();
    bus.flush = 1'b0;
    bus.FlagW = 2'b00;
    bus.Cond = 4'b0001;
    settle();
    check("fl_act", 8'(bus.it_active), 8'h0);
    check("fl_rem", 8'(bus.it_remaining), 8'h0);
    check("fl_flags", 8'(bus.Flags), 8'h04);
    check("fl_ne", 8'(bus.CondEx), 8'h0);
    bus.Cond = 4'b0000;
    settle();
    check("fl_eq", 8'(bus.CondEx), 8'h1);

    // Bad length, then nested it_start.
    bus.it_start = 1'b1;
    bus.it_len = 3'd0;
    settle();
    check("bad_cex", 8'(bus.CondEx), 8'h1);
    tick();
    bus.it_start = 1'b0;
    bus.en = 1'b0;
    settle();
    check("bad_err", 8'(bus.it_err), 8'h1);
    check("bad_act", 8'(bus.it_active), 8'h0);
    tick();
    check("err_hold", 8'(bus.it_err), 8'h1);
    bus.en = 1'b1;
    tick();
    check("err_clr", 8'(bus.it_err), 8'h0);
    bus.it_start = 1'b1;
    bus.it_cond = 4'b0000;
    bus.it_len = 3'd2;
    bus.it_then = 4'b0010;
    tick();
    bus.it_len = 3'd1;
    settle();
    check("nest_cex", 8'(bus.CondEx), 8'h0);
    tick();
    bus.it_start = 1'b0;
    settle();
    check("nest_err", 8'(bus.it_err), 8'h1);
    check("nest_rem", 8'(bus.it_remaining), 8'h1);
    check("nest_act", 8'(bus.it_active), 8'h1);
    check("nest_s2", 8'(bus.CondEx), 8'h1);
    tick();
    check("nest_end_err", 8'(bus.it_err), 8'h0);
    check("nest_end_act", 8'(bus.it_active), 8'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cond_exec_unit.md
Name: cond_exec_unit

Overview:
- Next-generation condition-check block for the CPU control unit.
- Holds the architectural NZCV flags in NBANKS banks, for example one bank per hardware context.
- Evaluates the 16 ARM condition codes against the flags of the selected bank.
- Adds an IT-block sequencer: one IT instruction predicates up to MAX_IT following instructions, each as "then" or "else". The Decoder and the datapath enable drive the block.

Parameters:
- NBANKS, default 2: number of independent NZCV flag banks; minimum 1.
- MAX_IT, default 4: maximum number of instructions in one IT block; minimum 1.
- BW, default $clog2(NBANKS) (1 when NBANKS=1): bank-select width.
- LW, default $clog2(MAX_IT+1): IT length / counter width.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset.
- en, input, 1: pipeline advance. No state changes when en=0.
- flush, input, 1: squashes the IT state. Priority over everything except reset.
- bank_sel, input, BW: flag bank used for evaluation and update.
- Cond, input, 4: instruction condition field. Used only outside an IT block.
- ALUFlags, input, 4: {N,Z,C,V} from the ALU.
- FlagW, input, 2: [1] writes N,Z; [0] writes C,V.
- it_start, input, 1: the current instruction is an IT instruction.
- it_cond, input, 4: IT firstcond.
- it_len, input, LW: number of predicated instructions, 1..MAX_IT.
- it_then, input, MAX_IT: per slot, 1=then, 0=else. Bit 0 is the first slot.
- CondEx, output, 1: the current instruction executes.
- Flags, output, 4: registered {N,Z,C,V} of the selected bank.
- it_active, output, 1: an IT block is in progress.
- it_remaining, output, LW: slots left in the current IT block.
- it_err, output, 1: registered one-cycle error pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - all banks' flags = 4'b0000;
  - it_active = 0, it_remaining = 0;
  - stored IT cond/mask = 0;
  - it_err = 0.
- Effective cond EC:
  - outside an IT block: EC = Cond;
  - inside an IT block: EC = {base[3:1], base[0] ^ ~mask[0]}, where mask[0] is the current slot's then-bit.
  - If base = 4'b1110 (AL), else-bits are treated as then, so EC stays 1110.
- CondEx table, evaluated on the registered Flags of bank_sel (GE = N==V):
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C;
  - 0100 N; 0101 ~N; 0110 V; 0111 ~V;
  - 1000 C&~Z; 1001 ~(C&~Z);
  - 1010 GE; 1011 ~GE; 1100 ~Z&GE; 1101 ~(~Z&GE);
  - 1110 and 1111: 1.
- Forced CondEx: when it_start=1 and it_active=0, CondEx = 1 (the IT instruction itself always executes).
- CondEx timing: combinational, no latency. It depends only on registered state and the current-cycle inputs Cond, bank_sel, it_start.
- Flag update, on a rising edge with en=1, flush=0 and CondEx=1:
  - bank_sel bank N,Z <= ALUFlags[3:2] if FlagW[1];
  - bank_sel bank C,V <= ALUFlags[1:0] if FlagW[0].
  - Other banks never change.
  - The new value is visible on Flags the next cycle. There is no bypass.
- IT sequencer, on a rising edge with en=1, flush=0:
  - Idle, it_start=1, 1<=it_len<=MAX_IT: load base<=it_cond, mask<=it_then, it_remaining<=it_len, it_active<=1.
  - Idle, it_start=1, it_len=0 or it_len>MAX_IT: no load; it_err<=1 next cycle.
  - Active (one slot consumed): it_remaining<=it_remaining-1; mask shifts right by 1 with zero fill; it_active<=0 when it_remaining==1.
  - Active, it_start=1: not an IT load. Consumes a slot normally, with CondEx from EC, and sets it_err<=1.
- Hold/flush/error pulse rules:
  - en=0: all registers hold, including it_err.
  - flush=1: it_active<=0, it_remaining<=0; the flag update for that cycle is suppressed.
  - it_err clears to 0 on the next en=1 cycle unless re-asserted.
- Slot consumption: a skipped slot (CondEx=0) still consumes a slot.
- bank_sel may change mid-IT block. Each slot evaluates against the bank selected in its own cycle.

Test Plan:
- Reset with banks pre-written, then reset=0 asynchronously mid-cycle -> Flags=0000, it_active=0, it_err=0 immediately, without waiting for a clock edge.
- Bank 0: FlagW=11, ALUFlags=0100, Cond=1110; then Cond=0000 -> CondEx=1, Flags=0100. Set bank_sel=1 -> Flags=0000 and Cond=0000 gives CondEx=0.
- Flags N=1,V=0: Cond=1010 -> CondEx=0; Cond=1011 -> 1; Cond=1101 -> 1. With FlagW=01 and ALUFlags=0001, then N=1,V=1: Cond=1010 -> 1.
- Z=1: it_start, it_cond=0000, it_len=3, it_then=0101; next three en cycles -> CondEx 1,0,1, it_remaining 3->2->1->0, it_active falls after slot 3. Skipped slot 2 with FlagW=11 leaves Flags unchanged.
- IT block loaded with it_len=4; en=0 for 2 cycles, then flush after slot 1 -> it_remaining holds at 4 while en=0; after flush it_active=0 and the next Cond is used directly.
- it_start with it_len=0 -> it_err=1 for one cycle, it_active stays 0. it_start inside an active block -> slot consumed, it_err=1.
